// File: rtl/ahb_pkg.sv
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite encodings, one-hot subordinate select type and
//               default-subordinate state enum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

   localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

   localparam logic c_HRESP_OKAY  = 1'b0;
   localparam logic c_HRESP_ERROR = 1'b1;

   localparam int c_SEL_W       = 4;
   localparam int c_SEL_S1_IDX  = 0;
   localparam int c_SEL_S2_IDX  = 1;
   localparam int c_SEL_S3_IDX  = 2;
   localparam int c_SEL_DEF_IDX = 3;

   typedef logic [c_SEL_W-1:0] sel_t;

   localparam sel_t c_SEL_S1  = sel_t'(1 << c_SEL_S1_IDX);
   localparam sel_t c_SEL_S2  = sel_t'(1 << c_SEL_S2_IDX);
   localparam sel_t c_SEL_S3  = sel_t'(1 << c_SEL_S3_IDX);
   localparam sel_t c_SEL_DEF = sel_t'(1 << c_SEL_DEF_IDX);

   typedef enum logic [1:0] {
      DS_IDLE = 2'b00,
      DS_ERR1 = 2'b01,
      DS_ERR2 = 2'b10
   } dsub_state_t;

   // HSELd and the all-zero (unmapped) case both resolve to DEF.
   function automatic sel_t f_prio_sel(input logic s1, input logic s2, input logic s3);
      if (s1)      return c_SEL_S1;
      else if (s2) return c_SEL_S2;
      else if (s3) return c_SEL_S3;
      else         return c_SEL_DEF;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_default_subordinate.sv
// ============================================================================
// Module      : ahb_default_subordinate
// Description : Answers unmapped/default-region transfers. With the macro
//               AHB_DEFAULT_ERROR_EN defined, NONSEQ/SEQ get a two-cycle
//               ERROR; otherwise every transfer gets a zero-wait OKAY.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_default_subordinate
   import ahb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_hready,
   input  logic i_sel_def,
   input  logic i_trans_active,
   output logic o_hreadyout,
   output logic o_hresp
);

`ifdef AHB_DEFAULT_ERROR_EN
   dsub_state_t r_state;
   logic        r_hreadyout;
   logic        r_hresp;
   logic        w_start;

   assign w_start = i_hready & i_sel_def & i_trans_active;

   // Outputs are registered alongside the state so they encode the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= DS_IDLE;
         r_hreadyout <= 1'b1;
         r_hresp     <= c_HRESP_OKAY;
      end else begin
         case (r_state)
            DS_IDLE: begin
               if (w_start) begin
                  r_state     <= DS_ERR1;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= c_HRESP_ERROR;
               end
            end
            DS_ERR1: begin
               r_state     <= DS_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= c_HRESP_ERROR;
            end
            DS_ERR2: begin
               if (w_start) begin
                  r_state     <= DS_ERR1;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= c_HRESP_ERROR;
               end else begin
                  r_state     <= DS_IDLE;
                  r_hreadyout <= 1'b1;
                  r_hresp     <= c_HRESP_OKAY;
               end
            end
            default: begin
               r_state     <= DS_IDLE;
               r_hreadyout <= 1'b1;
               r_hresp     <= c_HRESP_OKAY;
            end
         endcase
      end
   end

   assign o_hreadyout = r_hreadyout;
   assign o_hresp     = r_hresp;
`else
   logic w_unused;
   assign w_unused    = ^{clk, rst_n, i_hready, i_sel_def, i_trans_active};
   assign o_hreadyout = 1'b1;
   assign o_hresp     = c_HRESP_OKAY;
`endif

endmodule

`default_nettype wire

// File: rtl/ahb_response_mux.sv
// ============================================================================
// Module      : ahb_response_mux
// Description : AHB-Lite manager-side response mux with data-phase select
//               register and built-in default subordinate. Optional feature
//               macro: AHB_DEFAULT_ERROR_EN (default-region ERROR responses).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_response_mux
   import ahb_pkg::*;
#(
   parameter int DATA_WIDTH         = 32,
   parameter int NO_OF_SUBORDINATES = 3
)(
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL1,
   input  logic                  HSEL2,
   input  logic                  HSEL3,
   input  logic                  HSELd,
   input  logic [1:0]            HTRANS,
   input  logic [DATA_WIDTH-1:0] HRDATA1,
   input  logic [DATA_WIDTH-1:0] HRDATA2,
   input  logic [DATA_WIDTH-1:0] HRDATA3,
   input  logic                  HREADYOUT1,
   input  logic                  HREADYOUT2,
   input  logic                  HREADYOUT3,
   input  logic                  HRESP1,
   input  logic                  HRESP2,
   input  logic                  HRESP3,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADY,
   output logic                  HRESP
);

   if (NO_OF_SUBORDINATES != 3) begin : g_cfg_check
      $error("ahb_response_mux supports exactly 3 subordinates");
   end

   sel_t                  w_asel;
   sel_t                  r_dsel;
   logic [DATA_WIDTH-1:0] w_hrdata;
   logic                  w_hready;
   logic                  w_hresp;
   logic                  w_hreadyout_d;
   logic                  w_hresp_d;
   logic                  w_unused;

   // HSELd carries no extra information beyond "none of S1..S3"; HTRANS[0]
   // only distinguishes IDLE/BUSY and NONSEQ/SEQ, which are treated alike.
   assign w_unused = ^{HSELd, HTRANS[0]};

   assign w_asel = f_prio_sel(HSEL1, HSEL2, HSEL3);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_dsel <= c_SEL_DEF;
      end else if (w_hready) begin
         r_dsel <= w_asel;
      end
   end

   ahb_default_subordinate u_default_sub (
      .clk            (HCLK),
      .rst_n          (HRESETn),
      .i_hready       (w_hready),
      .i_sel_def      (w_asel[c_SEL_DEF_IDX]),
      .i_trans_active (HTRANS[1]),
      .o_hreadyout    (w_hreadyout_d),
      .o_hresp        (w_hresp_d)
   );

   always_comb begin
      w_hrdata = '0;
      w_hready = w_hreadyout_d;
      w_hresp  = w_hresp_d;
      case (r_dsel)
         c_SEL_S1: begin
            w_hrdata = HRDATA1;
            w_hready = HREADYOUT1;
            w_hresp  = HRESP1;
         end
         c_SEL_S2: begin
            w_hrdata = HRDATA2;
            w_hready = HREADYOUT2;
            w_hresp  = HRESP2;
         end
         c_SEL_S3: begin
            w_hrdata = HRDATA3;
            w_hready = HREADYOUT3;
            w_hresp  = HRESP3;
         end
         default: begin
            w_hrdata = '0;
            w_hready = w_hreadyout_d;
            w_hresp  = w_hresp_d;
         end
      endcase
   end

   assign HRDATA = w_hrdata;
   assign HREADY = w_hready;
   assign HRESP  = w_hresp;

endmodule

`default_nettype wire

// File: tb/tb_ahb_response_mux.sv
// ============================================================================
// Module      : tb_ahb_response_mux
// Description : Self-checking bench for ahb_response_mux (honours the
//               AHB_DEFAULT_ERROR_EN macro).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_response_mux;

`ifdef AHB_DEFAULT_ERROR_EN
   localparam bit c_ERR_EN = 1'b1;
`else
   localparam bit c_ERR_EN = 1'b0;
`endif

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic        HSEL1 = 0, HSEL2 = 0, HSEL3 = 0, HSELd = 0;
   logic [1:0]  HTRANS = 2'b00;
   logic [31:0] HRDATA1 = 0, HRDATA2 = 0, HRDATA3 = 0;
   logic        HREADYOUT1 = 1, HREADYOUT2 = 1, HREADYOUT3 = 1;
   logic        HRESP1 = 0, HRESP2 = 0, HRESP3 = 0;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   int errors = 0;
   int checks = 0;

   ahb_response_mux #(.DATA_WIDTH(32), .NO_OF_SUBORDINATES(3)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .HSEL1(HSEL1), .HSEL2(HSEL2), .HSEL3(HSEL3), .HSELd(HSELd),
      .HTRANS(HTRANS),
      .HRDATA1(HRDATA1), .HRDATA2(HRDATA2), .HRDATA3(HRDATA3),
      .HREADYOUT1(HREADYOUT1), .HREADYOUT2(HREADYOUT2), .HREADYOUT3(HREADYOUT3),
      .HRESP1(HRESP1), .HRESP2(HRESP2), .HRESP3(HRESP3),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   // Model: which target owns the data phase (0 = default, 1..3 = real) and
   // how far into a default ERROR response we are (0 none, 1 first, 2 second).
   int m_tgt = 0;
   int m_err = 0;

   function automatic int prio_target();
      if (HSEL1)      return 1;
      else if (HSEL2) return 2;
      else if (HSEL3) return 3;
      else            return 0;
   endfunction

   function automatic logic [31:0] exp_data();
      case (m_tgt)
         1: return HRDATA1;
         2: return HRDATA2;
         3: return HRDATA3;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic exp_ready();
      case (m_tgt)
         1: return HREADYOUT1;
         2: return HREADYOUT2;
         3: return HREADYOUT3;
         default: return (m_err == 1) ? 1'b0 : 1'b1;
      endcase
   endfunction

   function automatic logic exp_resp();
      case (m_tgt)
         1: return HRESP1;
         2: return HRESP2;
         3: return HRESP3;
         default: return (m_err != 0) ? 1'b1 : 1'b0;
      endcase
   endfunction

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         m_tgt = 0;
         m_err = 0;
      end else if (m_err == 1) begin
         m_err = 2;
      end else if (exp_ready()) begin
         m_tgt = prio_target();
         m_err = (m_tgt == 0 && HTRANS[1] && c_ERR_EN) ? 1 : 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge HCLK) begin
      chk("model_hrdata", HRDATA, exp_data());
      chk("model_hready", {31'b0, HREADY}, {31'b0, exp_ready()});
      chk("model_hresp",  {31'b0, HRESP},  {31'b0, exp_resp()});
   end

   task automatic next_cycle();
      @(posedge HCLK);
      #1;
   endtask

   task automatic addr(input logic s1, input logic s2, input logic s3, input logic sd,
                       input logic [1:0] tr);
      HSEL1 = s1; HSEL2 = s2; HSEL3 = s3; HSELd = sd; HTRANS = tr;
   endtask

   task automatic chk_out(input string name, input logic [31:0] d, input logic r, input logic p);
      chk({name, "_hrdata"}, HRDATA, d);
      chk({name, "_hready"}, {31'b0, HREADY}, {31'b0, r});
      chk({name, "_hresp"},  {31'b0, HRESP},  {31'b0, p});
   endtask

   initial begin
      #1 HRESETn = 1'b0;
      // Reset with random inputs
      for (int i = 0; i < 5; i++) begin
         addr($urandom, $urandom, $urandom, $urandom, 2'($urandom));
         HRDATA1 = $urandom; HRDATA2 = $urandom; HRDATA3 = $urandom;
         HREADYOUT1 = $urandom; HREADYOUT2 = $urandom; HREADYOUT3 = $urandom;
         HRESP1 = $urandom; HRESP2 = $urandom; HRESP3 = $urandom;
         @(negedge HCLK);
         chk_out("reset", 32'h0, 1'b1, 1'b0);
         next_cycle();
      end
      addr(0, 0, 0, 0, 2'b00);
      HREADYOUT1 = 1; HREADYOUT2 = 1; HREADYOUT3 = 1;
      HRESP1 = 0; HRESP2 = 0; HRESP3 = 0;
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk_out("post_reset", 32'h0, 1'b1, 1'b0);
      next_cycle();

      // Read from S2
      addr(0, 1, 0, 0, 2'b10);
      next_cycle();
      addr(0, 0, 0, 0, 2'b00);
      HRDATA2 = 32'hA5A5_0002;
      @(negedge HCLK);
      chk_out("s2_read", 32'hA5A5_0002, 1'b1, 1'b0);
      next_cycle();

      // S1 wait states with S3 queued on the address bus
      HRDATA1 = 32'h1111_1111; HRDATA3 = 32'h3333_3333;
      addr(1, 0, 0, 0, 2'b10);
      next_cycle();
      addr(0, 0, 1, 0, 2'b10);
      HREADYOUT1 = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         chk_out("s1_wait", 32'h1111_1111, 1'b0, 1'b0);
         next_cycle();
      end
      HREADYOUT1 = 1;
      @(negedge HCLK);
      chk_out("s1_done", 32'h1111_1111, 1'b1, 1'b0);
      next_cycle();
      addr(0, 0, 0, 0, 2'b00);
      @(negedge HCLK);
      chk_out("s3_data", 32'h3333_3333, 1'b1, 1'b0);
      next_cycle();

      // Default subordinate NONSEQ
      addr(0, 0, 0, 1, 2'b10);
      next_cycle();
      addr(0, 0, 0, 0, 2'b00);
      @(negedge HCLK);
      chk_out("def_c1", 32'h0, !c_ERR_EN, c_ERR_EN);
      next_cycle();
      if (c_ERR_EN) begin
         @(negedge HCLK);
         chk_out("def_c2", 32'h0, 1'b1, 1'b1);
         next_cycle();
      end
      @(negedge HCLK);
      chk_out("def_after", 32'h0, 1'b1, 1'b0);
      next_cycle();

      // Unmapped SEQ, then back-to-back default NONSEQ accepted during ERR2
      addr(0, 0, 0, 0, 2'b11);
      next_cycle();
      addr(0, 0, 0, 0, 2'b00);
      if (c_ERR_EN) begin
         @(negedge HCLK);
         chk_out("unm_c1", 32'h0, 1'b0, 1'b1);
         next_cycle();
         addr(0, 0, 0, 1, 2'b10);
         @(negedge HCLK);
         chk_out("unm_c2", 32'h0, 1'b1, 1'b1);
         next_cycle();
         addr(0, 0, 0, 0, 2'b00);
         @(negedge HCLK);
         chk_out("b2b_c1", 32'h0, 1'b0, 1'b1);
         next_cycle();
         next_cycle();
      end
      // Unmapped IDLE and default BUSY: zero-wait OKAY
      addr(0, 0, 0, 0, 2'b00);
      next_cycle();
      addr(0, 0, 0, 1, 2'b01);
      @(negedge HCLK);
      chk_out("unm_idle", 32'h0, 1'b1, 1'b0);
      next_cycle();
      addr(0, 0, 0, 0, 2'b00);
      @(negedge HCLK);
      chk_out("def_busy", 32'h0, 1'b1, 1'b0);
      next_cycle();

      // Priority: S1 wins over S3 and HSELd
      HRDATA1 = 32'h0000_00F1;
      addr(1, 0, 1, 1, 2'b10);
      next_cycle();
      addr(0, 0, 0, 0, 2'b00);
      @(negedge HCLK);
      chk_out("prio", 32'h0000_00F1, 1'b1, 1'b0);
      next_cycle();

      // Reset asserted during ERR1
      addr(0, 0, 0, 1, 2'b10);
      next_cycle();
      addr(0, 0, 0, 0, 2'b00);
      chk("pre_rst_hready", {31'b0, HREADY}, {31'b0, !c_ERR_EN});
      #1 HRESETn = 1'b0;
      #1 chk_out("rst_err1", 32'h0, 1'b1, 1'b0);
      next_cycle();
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk_out("rst_release", 32'h0, 1'b1, 1'b0);
      next_cycle();

      // Random patterns, model-checked
      for (int i = 0; i < 60; i++) begin
         addr($urandom, $urandom, $urandom, $urandom, 2'($urandom));
         HRDATA1 = $urandom; HRDATA2 = $urandom; HRDATA3 = $urandom;
         HREADYOUT1 = ($urandom_range(3) != 0);
         HREADYOUT2 = ($urandom_range(3) != 0);
         HREADYOUT3 = ($urandom_range(3) != 0);
         HRESP1 = $urandom; HRESP2 = $urandom; HRESP3 = $urandom;
         next_cycle();
      end

      @(negedge HCLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
